// File: rtl/mem_bus_responder_pkg.sv
// Shared types and parameter defaults for the memory bus responder and its RAM.
package mem_bus_responder_pkg;

    localparam int DEPTH_DEF       = 1024;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int ADDR_SIZE_DEF   = 16;
    localparam int DATA_SIZE_DEF   = 16;
    localparam int CNT_W           = 4;   // holds WAIT_CYCLES up to 15

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port word RAM with synchronous read; one access per cycle.
module mem_bus_resp_ram #(
    parameter int DEPTH     = 1024,
    parameter int DATA_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_SIZE-1:0]     wdata,
    output logic [DATA_SIZE-1:0]     rdata
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset; contents must survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Wait-state memory bus responder with level request / done handshake.
// Define MEM_BUS_RESP_ADDR_CHECK_EN to reject addresses >= DEPTH instead of wrapping.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
    parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_q,
    input  logic                 write_q,
    input  logic [ADDR_SIZE-1:0] addr_in,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 read_dn,
    output logic                 write_dn,
    output logic                 bus_busy,
    output logic                 resp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 op_write;
    logic [ADDR_SIZE-1:0] addr_lat;
    logic [DATA_SIZE-1:0] data_lat;
    logic [DATA_SIZE-1:0] ram_rdata;
    logic                 addr_err;
    logic                 accept;
    logic                 ram_we, ram_re;

    assign accept = (state == ST_IDLE) && (read_q || write_q);

`ifdef MEM_BUS_RESP_ADDR_CHECK_EN
    assign addr_err = (32'(addr_lat) >= 32'(DEPTH));
`else
    assign addr_err = 1'b0;
    // Upper address bits are ignored when wrapping modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_lat;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Write wins a simultaneous request; the read is re-sampled after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write <= 1'b0;
            addr_lat <= '0;
            data_lat <= '0;
        end else if (accept) begin
            op_write <= write_q;
            addr_lat <= addr_in;
            data_lat <= data_in;
        end
    end

    // NOTE: defaults first so every path assigns each output; no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (read_q || write_q) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = ST_RESP;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nx = ST_RESP;
            end
            ST_RESP:    state_nx = ST_RELEASE;
            ST_RELEASE: if (!(op_write ? write_q : read_q)) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        read_dn  = 1'b0;
        write_dn = 1'b0;
        resp_err = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        bus_busy = (state != ST_IDLE);
        if (state == ST_RESP) begin
            ram_we   = op_write && !addr_err;
            ram_re   = !op_write && !addr_err;
            resp_err = addr_err;
        end
        if (state == ST_RELEASE) begin
            read_dn  = !op_write;
            write_dn = op_write;
        end
    end

    assign data_out = (read_dn && !addr_err) ? ram_rdata : '0;

    mem_bus_resp_ram #(
        .DEPTH     (DEPTH),
        .DATA_SIZE (DATA_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (addr_lat[IDX_W-1:0]),
        .wdata (data_lat),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: one responder with two wait states, one with none, sharing the request inputs.
module tb_mem_bus_responder;

    localparam int DEPTH = 1024;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        read_q  = 1'b0;
    logic        write_q = 1'b0;
    logic [15:0] addr_in = '0;
    logic [15:0] data_in = '0;

    logic [15:0] data_out_a, data_out_b;
    logic        read_dn_a, write_dn_a, bus_busy_a, resp_err_a;
    logic        read_dn_b, write_dn_b, bus_busy_b, resp_err_b;

    mem_bus_responder #(
        .DEPTH (DEPTH), .WAIT_CYCLES (2), .ADDR_SIZE (16), .DATA_SIZE (16)
    ) dut_a (
        .clk (clk), .rst (rst), .read_q (read_q), .write_q (write_q),
        .addr_in (addr_in), .data_in (data_in), .data_out (data_out_a),
        .read_dn (read_dn_a), .write_dn (write_dn_a), .bus_busy (bus_busy_a),
        .resp_err (resp_err_a)
    );

    mem_bus_responder #(
        .DEPTH (DEPTH), .WAIT_CYCLES (0), .ADDR_SIZE (16), .DATA_SIZE (16)
    ) dut_b (
        .clk (clk), .rst (rst), .read_q (read_q), .write_q (write_q),
        .addr_in (addr_in), .data_in (data_in), .data_out (data_out_b),
        .read_dn (read_dn_b), .write_dn (write_dn_b), .bus_busy (bus_busy_b),
        .resp_err (resp_err_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rdata;
        int          exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // {read_dn, write_dn, bus_busy, resp_err, data_out} of the selected instance
    function automatic logic [19:0] outs(input bit sel);
        return sel ? {read_dn_b, write_dn_b, bus_busy_b, resp_err_b, data_out_b}
                   : {read_dn_a, write_dn_a, bus_busy_a, resp_err_a, data_out_a};
    endfunction

    // Full handshake; cycle 0 is the cycle in which the request is raised.
    task automatic txn(input string name, input bit sel, input bit wr,
                       input logic [15:0] a, input logic [15:0] d,
                       input int exp_lat, input logic [15:0] exp_rdata, input int exp_err);
        logic [19:0] o;
        logic [15:0] rdata;
        logic [1:0]  busy_early;
        int          lat;
        int          errs;
        bit          leak;
        @(posedge clk); #1;
        read_q = !wr; write_q = wr; addr_in = a; data_in = d;
        lat = -1; errs = 0; leak = 0; rdata = '0; busy_early = '0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            o = outs(sel);
            if (c == 1) begin
                addr_in = ~a;
                data_in = ~d;
            end
            if (c < 2) busy_early[c] = o[17];
            if (o[16]) errs++;
            if (!o[19] && o[15:0] != 16'h0) leak = 1;
            if (wr ? o[18] : o[19]) begin
                lat   = c;
                rdata = o[15:0];
                break;
            end
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy c0/c1"}, busy_early, 2'b10);
        check({name, " resp_err"}, errs, exp_err);
        check({name, " data leak"}, leak, 1'b0);
        if (!wr) check({name, " rdata"}, rdata, exp_rdata);
        @(posedge clk); #1;
        read_q = 1'b0; write_q = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, " released"}, outs(sel), 20'h0);
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        bit          rd_early;
        int          e;

`ifdef MEM_BUS_RESP_ADDR_CHECK_EN
        e = 1;
`else
        e = 0;
`endif
        vecs[0]  = '{1'b1, 16'd5,    16'hA5A5, 16'h0000, 0};
        vecs[1]  = '{1'b0, 16'd5,    16'h0000, 16'hA5A5, 0};
        vecs[2]  = '{1'b1, 16'd3,    16'h0303, 16'h0000, 0};
        vecs[3]  = '{1'b1, 16'd1023, 16'hBEEF, 16'h0000, 0};
        vecs[4]  = '{1'b0, 16'd1023, 16'h0000, 16'hBEEF, 0};
        vecs[5]  = '{1'b1, 16'd0,    16'h0001, 16'h0000, 0};
        vecs[6]  = '{1'b0, 16'd0,    16'h0000, 16'h0001, 0};
        vecs[7]  = '{1'b0, 16'd3,    16'h0000, 16'h0303, 0};
        vecs[8]  = '{1'b1, 16'd1027, 16'h5A5A, 16'h0000, e};
        vecs[9]  = '{1'b0, 16'd3,    16'h0000, (e != 0) ? 16'h0303 : 16'h5A5A, 0};
        vecs[10] = '{1'b0, 16'd1027, 16'h0000, (e != 0) ? 16'h0000 : 16'h5A5A, e};

        #12;
        check("reset outputs a", outs(1'b0), 20'h0);
        check("reset outputs b", outs(1'b1), 20'h0);
        @(negedge clk); rst = 1'b1;

        foreach (vecs[i])
            txn($sformatf("vec%0d", i), 1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data,
                4, vecs[i].exp_rdata, vecs[i].exp_err);

        // Reset in the middle of WAIT aborts a pending write to word 5.
        @(posedge clk); #1;
        write_q = 1'b1; addr_in = 16'd5; data_in = 16'h1234;
        @(negedge clk); @(negedge clk);
        check("rst mid-wait busy before", bus_busy_a, 1'b1);
        rst = 1'b0; #1;
        check("rst mid-wait outputs", outs(1'b0), 20'h0);
        write_q = 1'b0;
        @(negedge clk); rst = 1'b1;
        txn("rst readback", 1'b0, 1'b0, 16'd5, 16'h0, 4, 16'hA5A5, 0);

        // Read dropped during WAIT: one-cycle done pulse, then idle.
        @(posedge clk); #1;
        read_q = 1'b1; addr_in = 16'd5;
        @(negedge clk); @(negedge clk);
        read_q = 1'b0;
        lat = -1; rd = '0;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (read_dn_a) begin
                lat = c;
                rd  = data_out_a;
                break;
            end
        end
        check("drop latency", lat, 4);
        check("drop rdata", rd, 16'hA5A5);
        @(negedge clk);
        check("drop pulse/busy", {read_dn_a, bus_busy_a}, 2'b00);
        txn("after drop", 1'b0, 1'b1, 16'd6, 16'h0606, 4, 16'h0, 0);

        // Simultaneous read and write: write first, read afterwards sees new data.
        @(posedge clk); #1;
        read_q = 1'b1; write_q = 1'b1; addr_in = 16'd7; data_in = 16'h0011;
        lat = -1; rd_early = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (read_dn_a) rd_early = 1;
            if (write_dn_a) begin
                lat = c;
                break;
            end
        end
        check("simul write latency", lat, 4);
        check("simul read not first", rd_early, 1'b0);
        @(posedge clk); #1;
        write_q = 1'b0;
        lat = -1; rd = '0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (read_dn_a) begin
                lat = c;
                rd  = data_out_a;
                break;
            end
        end
        check("simul read done seen", (lat >= 0), 1'b1);
        check("simul read rdata", rd, 16'h0011);
        @(posedge clk); #1;
        read_q = 1'b0;
        @(posedge clk); @(negedge clk);
        check("simul released", outs(1'b0), 20'h0);

        // Zero wait states on the second instance.
        txn("w0 write", 1'b1, 1'b1, 16'd9, 16'h0909, 2, 16'h0, 0);
        txn("w0 read",  1'b1, 1'b0, 16'd9, 16'h0, 2, 16'h0909, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
